// File: rtl/hex_display_pkg.sv
// Shared constants for the hex_display block: segment codes and page encoding.
package hex_display_pkg;

  // Segment codes, bit order {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;

  // Which quantity the eight digits show.
  typedef enum logic {
    PAGE_VALUE = 1'b0,
    PAGE_COUNT = 1'b1
  } page_t;

endpackage

// File: rtl/hex_display_if.sv
// CPU temporary result port: 32-bit value plus a one-cycle-per-trigger strobe.
interface hex_display_if;
  logic [31:0] data_in;
  logic        data_trg;

  modport master (output data_in, output data_trg);
  modport slave  (input  data_in, input  data_trg);
endinterface

// File: rtl/hex_display_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stability counter and a
// press pulse on the released->pressed transition of the debounced level.
module debounce #(
  parameter int DEB_CYCLES = 2000000,
  parameter int DEB_BITS   = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic in_n,
  output logic level,
  output logic press
);

  localparam logic [DEB_BITS-1:0] CNT_LAST = DEB_BITS'(DEB_CYCLES - 1);

  logic                s1;
  logic                ks;
  logic                db;
  logic [DEB_BITS-1:0] cnt;
  logic                accept;

  // The synchronised level has differed from db for DEB_CYCLES edges,
  // counting this one, so db takes it on this edge.
  assign accept = (ks != db) && (cnt == CNT_LAST);

  // Synchroniser and debounce counter; any equal sample restarts the count.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // so s1 -> ks forms a true two-stage chain regardless of statement order.
    if (rst) begin
      s1  <= 1'b1;
      ks  <= 1'b1;
      db  <= 1'b1;
      cnt <= '0;
    end else begin
      s1 <= in_n;
      ks <= s1;
      if (ks == db) begin
        cnt <= '0;
      end else if (accept) begin
        db  <= ks;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = db;
  // High during the cycle whose closing edge moves db from 1 to 0.
  assign press = accept & db;

endmodule

// File: rtl/hex_display.sv
// Captures the CPU's temporary result, counts triggers and drives the eight
// seven-segment digits with either the value or the trigger count.
module hex_display
  import hex_display_pkg::*;
#(
  parameter int DEB_CYCLES = 2000000,
  parameter int DEB_BITS   = 21
) (
  input  logic            clk,
  input  logic            rst,
  hex_display_if.slave    cpu,
  input  logic            key_n,
  output logic            page,
  output logic            valid,
  output logic [15:0]     trg_cnt,
  output logic [6:0]      hex7_n,
  output logic [6:0]      hex6_n,
  output logic [6:0]      hex5_n,
  output logic [6:0]      hex4_n,
  output logic [6:0]      hex3_n,
  output logic [6:0]      hex2_n,
  output logic [6:0]      hex1_n,
  output logic [6:0]      hex0_n
);

  logic [31:0] value;
  page_t       page_q;
  logic        key_level;
  logic        press;
  logic [6:0]  dig_next [8];

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: seg_of = SEG_0;
      4'h1: seg_of = SEG_1;
      4'h2: seg_of = SEG_2;
      4'h3: seg_of = SEG_3;
      4'h4: seg_of = SEG_4;
      4'h5: seg_of = SEG_5;
      4'h6: seg_of = SEG_6;
      4'h7: seg_of = SEG_7;
      4'h8: seg_of = SEG_8;
      4'h9: seg_of = SEG_9;
      4'hA: seg_of = SEG_A;
      4'hB: seg_of = SEG_B;
      4'hC: seg_of = SEG_C;
      4'hD: seg_of = SEG_D;
      4'hE: seg_of = SEG_E;
      default: seg_of = SEG_F;
    endcase
  endfunction

  debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_BITS   (DEB_BITS)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .in_n  (key_n),
    .level (key_level),
    .press (press)
  );

  // A press pulse always leaves the debounced level in the pressed state.
  assert property (@(posedge clk) disable iff (rst) press |=> !key_level);

  // Capture, trigger count and page select; trigger and press are independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      value   <= '0;
      valid   <= 1'b0;
      trg_cnt <= '0;
      page_q  <= PAGE_VALUE;
    end else begin
      if (cpu.data_trg) begin
        value   <= cpu.data_in;
        valid   <= 1'b1;
        trg_cnt <= trg_cnt + 16'd1;
      end
      if (press) begin
        page_q <= (page_q == PAGE_VALUE) ? PAGE_COUNT : PAGE_VALUE;
      end
    end
  end

  assign page = page_q;

  // Next digit pattern from the current captured state and page.
  always_comb begin
    // NOTE: every element gets a default first so no path leaves a digit
    // unassigned, which would otherwise infer a latch.
    for (int i = 0; i < 8; i++) dig_next[i] = SEG_BLANK;
    if (valid) begin
      if (page_q == PAGE_VALUE) begin
        for (int i = 0; i < 8; i++) dig_next[i] = seg_of(value[4*i +: 4]);
      end else begin
        for (int i = 0; i < 4; i++) dig_next[i] = seg_of(trg_cnt[4*i +: 4]);
      end
    end
  end

  // Registered segment outputs, one edge behind the captured state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hex7_n <= SEG_BLANK;
      hex6_n <= SEG_BLANK;
      hex5_n <= SEG_BLANK;
      hex4_n <= SEG_BLANK;
      hex3_n <= SEG_BLANK;
      hex2_n <= SEG_BLANK;
      hex1_n <= SEG_BLANK;
      hex0_n <= SEG_BLANK;
    end else begin
      hex7_n <= dig_next[7];
      hex6_n <= dig_next[6];
      hex5_n <= dig_next[5];
      hex4_n <= dig_next[4];
      hex3_n <= dig_next[3];
      hex2_n <= dig_next[2];
      hex1_n <= dig_next[1];
      hex0_n <= dig_next[0];
    end
  end

endmodule
